// File: rtl/execute_wb_port_pkg.sv
// Common execute/writeback types: the result pack an execute unit hands to writeback.
package execute_wb_port_pkg;

    typedef struct packed {
        logic        enable;
        logic        valid;
        logic        has_exception;
        logic [3:0]  exception_cause;
        logic [4:0]  rd_addr;
        logic [31:0] rd_value;
        logic [5:0]  rob_tag;
    } execute_wb_pack_t;

    localparam int EXECUTE_WB_PACK_W = $bits(execute_wb_pack_t);

endpackage

// File: rtl/execute_wb_port.sv
// Small FIFO between an execute unit and writeback, cleared by pipeline flush.
// Define WB_PORT_BYPASS_EN to present a push into an empty buffer in the same cycle.
module execute_wb_port
    import execute_wb_port_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int DEPTH_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  execute_wb_pack_t data_in,
    input  logic             we,
    input  logic             flush,
    output execute_wb_pack_t data_out,
    output logic             data_out_valid,
    input  logic             pop,
    output logic             full,
    output logic [DEPTH_W:0] count
);

    execute_wb_pack_t entries [DEPTH];
    logic [DEPTH_W:0] rptr;
    logic [DEPTH_W:0] wptr;
    logic             empty;
    logic             push_ok;
    logic             do_push;
    logic             do_pop;
    execute_wb_pack_t head;

    assign empty = (rptr == wptr);
    assign full  = (rptr[DEPTH_W-1:0] == wptr[DEPTH_W-1:0]) && (rptr[DEPTH_W] != wptr[DEPTH_W]);
    assign count = wptr - rptr;
    assign head  = entries[rptr[DEPTH_W-1:0]];

    // full blocks we regardless of pop, so pop never feeds back into acceptance
    assign push_ok = we && !full && !flush;

`ifdef WB_PORT_BYPASS_EN
    logic bypass_hit;
    logic bypass_consumed;

    assign bypass_hit      = empty && push_ok;
    assign bypass_consumed = bypass_hit && pop;
    assign data_out        = bypass_hit ? data_in : head;
    assign data_out_valid  = !empty || bypass_hit;
    // a bypassed result that is popped the same cycle is never written
    assign do_push         = push_ok && !bypass_consumed;
    assign do_pop          = pop && !empty && !flush;
`else
    assign data_out        = head;
    assign data_out_valid  = !empty;
    assign do_push         = push_ok;
    assign do_pop          = pop && !empty && !flush;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // storage is left unreset; data_out is only meaningful with data_out_valid
    always_ff @(posedge clk) begin
        if (do_push) entries[wptr[DEPTH_W-1:0]] <= data_in;
    end

endmodule

// File: tb/tb_execute_wb_port.sv
// Self-checking bench for execute_wb_port against a queue-based reference model.
module tb_execute_wb_port;
    import execute_wb_port_pkg::*;

    localparam int DEPTH = 2;
`ifdef WB_PORT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    execute_wb_pack_t data_in;
    logic             we;
    logic             flush;
    execute_wb_pack_t data_out;
    logic             data_out_valid;
    logic             pop;
    logic             full;
    logic [1:0]       count;

    int tests_run = 0;
    int tests_failed = 0;

    execute_wb_pack_t q[$];

    execute_wb_port #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .flush(flush),
        .data_out(data_out), .data_out_valid(data_out_valid), .pop(pop),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    function automatic execute_wb_pack_t mk(input logic [31:0] v);
        execute_wb_pack_t p;
        p.enable          = 1'($urandom_range(0, 1));
        p.valid           = 1'($urandom_range(0, 1));
        p.has_exception   = 1'($urandom_range(0, 1));
        p.exception_cause = 4'($urandom_range(0, 15));
        p.rd_addr         = 5'($urandom_range(0, 31));
        p.rd_value        = v;
        p.rob_tag         = 6'($urandom_range(0, 63));
        return p;
    endfunction

    function automatic bit exp_valid();
        return (q.size() > 0) || (BYPASS && q.size() == 0 && we && !flush);
    endfunction

    function automatic execute_wb_pack_t exp_head();
        return (q.size() > 0) ? q[0] : data_in;
    endfunction

    task automatic drive(input logic w, input execute_wb_pack_t d, input logic p, input logic f);
        we = w; data_in = d; pop = p; flush = f;
        #1;
    endtask

    // advance model and DUT by one edge using the currently driven inputs
    task automatic tick();
        int n;
        bit acc;
        bit byp;
        n = q.size();
        if (rst || flush) begin
            q.delete();
        end else begin
            acc = we && (n < DEPTH);
            byp = BYPASS && (n == 0) && acc && pop;
            if (!byp) begin
                if (pop && n > 0) void'(q.pop_front());
                if (acc) q.push_back(data_in);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, mk(32'h0), 1'b0, 1'b0);
            tests_run++;
            if (data_out_valid !== 1'b0 || full !== 1'b0 || count !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: valid=%b full=%b count=%0d expected 0 0 0", i, data_out_valid, full, count);
            end
            tick();
        end
    endtask

    task automatic test_fill_full();
        execute_wb_pack_t p11, p22, p33;
        p11 = mk(32'h11); p22 = mk(32'h22); p33 = mk(32'h33);
        drive(1'b1, p11, 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== BYPASS || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL fill_first: valid=%b count=%0d expected %b 0", data_out_valid, count, BYPASS);
        end
        tick();
        drive(1'b1, p22, 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== 1'b1 || data_out.rd_value !== 32'h11 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL fill_second: valid=%b rd=%0h count=%0d expected 1 11 1", data_out_valid, data_out.rd_value, count);
        end
        tick();
        drive(1'b1, p33, 1'b0, 1'b0);
        tests_run++;
        if (full !== 1'b1 || count !== 2'd2) begin
            tests_failed++;
            $display("FAIL fill_full: full=%b count=%0d expected 1 2", full, count);
        end
        tick();
        drive(1'b0, p33, 1'b1, 1'b0);
        tests_run++;
        if (count !== 2'd2 || data_out !== p11 || data_out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_ignores_we: count=%0d head=%0h expected 2 %0h", count, data_out, p11);
        end
        tick();
        drive(1'b0, p33, 1'b1, 1'b0);
        tests_run++;
        if (data_out !== p22 || data_out_valid !== 1'b1 || full !== 1'b0 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL pop_second: head=%0h full=%b count=%0d expected %0h 0 1", data_out, full, count, p22);
        end
        tick();
        drive(1'b0, p33, 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== 1'b0 || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL drained: valid=%b count=%0d expected 0 0", data_out_valid, count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, mk(32'h66), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(32'h44), 1'b1, 1'b1);
        tests_run++;
        if (data_out_valid !== 1'b1 || data_out.rd_value !== 32'h66 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL flush_pre: valid=%b rd=%0h count=%0d expected 1 66 1", data_out_valid, data_out.rd_value, count);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, mk(32'h0), 1'b0, 1'b0);
            tests_run++;
            if (data_out_valid !== 1'b0 || count !== 2'd0) begin
                tests_failed++;
                $display("FAIL flush_post cycle %0d: valid=%b count=%0d rd=%0h expected 0 0", i, data_out_valid, count, data_out.rd_value);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        drive(1'b1, mk(32'd0), 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 20; i++) begin
            drive(1'b1, mk(32'(i)), 1'b1, 1'b0);
            tests_run++;
            if (data_out_valid !== 1'b1 || data_out.rd_value !== 32'(i - 1) || count !== 2'd1) begin
                tests_failed++;
                $display("FAIL stream %0d: valid=%b rd=%0d count=%0d expected 1 %0d 1", i, data_out_valid, data_out.rd_value, count, i - 1);
            end
            tick();
        end
        drive(1'b0, mk(32'd0), 1'b1, 1'b0);
        tests_run++;
        if (data_out.rd_value !== 32'd19 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL stream_last: rd=%0d count=%0d expected 19 1", data_out.rd_value, count);
        end
        tick();
        drive(1'b0, mk(32'd0), 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== 1'b0 || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL stream_drain: valid=%b count=%0d expected 0 0", data_out_valid, count);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, mk(32'h55), 1'b1, 1'b0);
`ifdef WB_PORT_BYPASS_EN
        tests_run++;
        if (data_out_valid !== 1'b1 || data_out.rd_value !== 32'h55 || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL bypass_same: valid=%b rd=%0h count=%0d expected 1 55 0", data_out_valid, data_out.rd_value, count);
        end
        tick();
        drive(1'b0, mk(32'h0), 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== 1'b0 || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL bypass_after: valid=%b count=%0d expected 0 0", data_out_valid, count);
        end
`else
        tests_run++;
        if (data_out_valid !== 1'b0 || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL nobypass_same: valid=%b count=%0d expected 0 0", data_out_valid, count);
        end
        tick();
        drive(1'b0, mk(32'h0), 1'b0, 1'b0);
        tests_run++;
        if (data_out_valid !== 1'b1 || data_out.rd_value !== 32'h55 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL nobypass_next: valid=%b rd=%0h count=%0d expected 1 55 1", data_out_valid, data_out.rd_value, count);
        end
        drive(1'b0, mk(32'h0), 1'b1, 1'b0);
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, mk(32'h77), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(32'h88), 1'b0, 1'b0);
        tick();
        drive(1'b0, mk(32'h0), 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd2 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: count=%0d full=%b expected 2 1", count, full);
        end
        rst = 1'b1;
        drive(1'b1, mk(32'hAA), 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, mk(32'h0), 1'b0, 1'b0);
        tests_run++;
        if (count !== 2'd0 || data_out_valid !== 1'b0 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_post: count=%0d valid=%b full=%b expected 0 0 0", count, data_out_valid, full);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), mk($urandom), 1'($urandom_range(0, 3) < 2),
                  1'($urandom_range(0, 15) == 0));
            tests_run++;
            if (data_out_valid !== exp_valid() || full !== (q.size() == DEPTH) || int'(count) !== q.size()) begin
                tests_failed++;
                $display("FAIL random_flags %0d: valid=%b full=%b count=%0d expected %b %b %0d", i, data_out_valid, full, count, exp_valid(), q.size() == DEPTH, q.size());
            end
            if (exp_valid()) begin
                tests_run++;
                if (data_out !== exp_head()) begin
                    tests_failed++;
                    $display("FAIL random_data %0d: got %0h expected %0h", i, data_out, exp_head());
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; pop = 1'b0; flush = 1'b0; data_in = '0;
        @(negedge clk);
        test_reset();
        test_fill_full();
        tick();
        test_flush();
        test_stream();
        tick();
        test_bypass();
        test_reset_mid();
        tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
